// File: rtl/smac_acc.sv
`default_nettype none
// -----------------------------------------------------------------------------
// smac_acc : handshaked signed accumulator that sums N_TERMS multiplier products
// Rev 1.0
// -----------------------------------------------------------------------------
module smac_acc #(
  parameter int N_TERMS = 8,
  parameter int ACC_W   = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      p,
  input  logic             p_valid,
  output logic             p_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ack,
  output logic             ovf,
  output logic             busy
);

  localparam int               CNT_W    = 8;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] p_ext;
  logic [ACC_W-1:0] sum;
  logic             xfer;
  logic             add_ovf;

  if (ACC_W > 32) begin : g_ext
    assign p_ext = {{(ACC_W-32){p[31]}}, p};
  end else begin : g_noext
    assign p_ext = p;
  end

  // p_ready is a registered copy of (state == ACC), so it gates transfers directly
  assign xfer    = p_valid && p_ready;
  assign sum     = acc + p_ext;
  assign add_ovf = (acc[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
  assign acc_out = acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      p_ready   <= 1'b0;
      acc_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ACC;
            cnt     <= '0;
            acc     <= '0;
            ovf     <= 1'b0;
            p_ready <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ACC: begin
          if (xfer) begin
            acc <= sum;
            cnt <= cnt + 1'b1;
            if (add_ovf) begin
              ovf <= 1'b1;
            end
            if (cnt == LAST_CNT) begin
              state     <= DONE;
              p_ready   <= 1'b0;
              acc_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (acc_ack) begin
            state     <= IDLE;
            acc_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          p_ready   <= 1'b0;
          acc_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_smac_acc.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_smac_acc : self-checking bench over five parameter sets of smac_acc
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_smac_acc;

  localparam int NCFG = 5;

  function automatic int nt_of(input int k);
    case (k)
      0:       return 4;
      1:       return 8;
      2:       return 3;
      3:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int aw_of(input int k);
    return (k == 2) ? 32 : 40;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NCFG-1:0]    rst;
  logic [NCFG-1:0]    start;
  logic [NCFG-1:0]    p_valid;
  logic [NCFG-1:0]    acc_ack;
  logic [NCFG-1:0]    p_ready;
  logic [NCFG-1:0]    acc_valid;
  logic [NCFG-1:0]    ovf;
  logic [NCFG-1:0]    busy;
  logic [31:0]        p_in   [NCFG];
  logic signed [63:0] acc_sx [NCFG];

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int AW = aw_of(g);
    logic [AW-1:0] acc_raw;
    smac_acc #(.N_TERMS(nt_of(g)), .ACC_W(AW)) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .start     (start[g]),
      .p         (p_in[g]),
      .p_valid   (p_valid[g]),
      .p_ready   (p_ready[g]),
      .acc_out   (acc_raw),
      .acc_valid (acc_valid[g]),
      .acc_ack   (acc_ack[g]),
      .ovf       (ovf[g]),
      .busy      (busy[g])
    );
    assign acc_sx[g] = 64'($signed(acc_raw));
  end

  typedef struct {
    int     k;
    int     prod [8];
    int     gap_max;
    bit     rnd;
    bit     pokes;
    int     hold;
    bit     ack_start;
    longint exp_acc;
    bit     exp_ovf;
  } vec_t;

  typedef struct {
    longint acc;
    bit     ovf;
  } exp_t;

  vec_t tbl [$];
  exp_t sb  [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: exact integer sum per step, folded back into range on overflow
  function automatic void model(input int k, input int pr [8], output longint acc, output bit ov);
    int     aw = aw_of(k);
    longint hi = (64'sd1 <<< (aw - 1)) - 1;
    longint lo = -(64'sd1 <<< (aw - 1));
    longint t;
    acc = 0;
    ov  = 1'b0;
    for (int i = 0; i < nt_of(k); i++) begin
      t = acc + longint'(pr[i]);
      if (t > hi) begin
        t  = t - (64'sd1 <<< aw);
        ov = 1'b1;
      end else if (t < lo) begin
        t  = t + (64'sd1 <<< aw);
        ov = 1'b1;
      end
      acc = t;
    end
  endfunction

  task automatic collect(input int k, output exp_t e);
    int w = 0;
    chk("acc_valid_latency", acc_valid[k], 1);
    while (!acc_valid[k] && w < 20) begin
      cyc();
      w++;
    end
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      e.acc = 0;
      e.ovf = 1'b0;
    end else begin
      e = sb.pop_front();
      chk("acc_out", acc_sx[k], e.acc);
      chk("ovf", ovf[k], e.ovf);
    end
  endtask

  task automatic run_row(input vec_t v);
    int   k = v.k;
    int   n = nt_of(k);
    int   pr [8];
    int   gap;
    exp_t e;
    pr = v.prod;
    if (v.rnd) begin
      for (int i = 0; i < n; i++) pr[i] = $urandom;
      model(k, pr, e.acc, e.ovf);
    end else begin
      e.acc = v.exp_acc;
      e.ovf = v.exp_ovf;
    end
    sb.push_back(e);

    if (v.pokes) begin
      p_valid[k] = 1'b1;
      p_in[k]    = 32'h1234_5678;
      cyc();
      p_valid[k] = 1'b0;
      chk("idle_ignores_p", busy[k], 0);
    end
    start[k] = 1'b1;
    cyc();
    start[k] = 1'b0;
    chk("start_busy", busy[k], 1);
    chk("start_p_ready", p_ready[k], 1);
    chk("start_ovf_clear", ovf[k], 0);
    chk("start_acc_clear", acc_sx[k], 0);
    if (v.pokes) begin
      start[k] = 1'b1;
      cyc();
      start[k] = 1'b0;
      chk("start_in_acc_ready", p_ready[k], 1);
    end

    for (int i = 0; i < n; i++) begin
      gap = (v.gap_max > 0) ? $urandom_range(v.gap_max, 0) : 0;
      repeat (gap) begin
        p_valid[k] = 1'b0;
        p_in[k]    = $urandom;
        cyc();
      end
      p_in[k]    = pr[i];
      p_valid[k] = 1'b1;
      cyc();
      p_valid[k] = 1'b0;
      p_in[k]    = $urandom;
      if (i < n - 1) chk("early_acc_valid", acc_valid[k], 0);
    end

    collect(k, e);
    repeat (v.hold) begin
      cyc();
      chk("hold_valid", acc_valid[k], 1);
      chk("hold_acc", acc_sx[k], e.acc);
      chk("hold_ovf", ovf[k], e.ovf);
    end
    if (v.pokes) begin
      start[k] = 1'b1;
      cyc();
      start[k] = 1'b0;
      chk("start_in_done_valid", acc_valid[k], 1);
      chk("start_in_done_acc", acc_sx[k], e.acc);
      chk("done_p_ready", p_ready[k], 0);
    end
    acc_ack[k] = 1'b1;
    start[k]   = v.ack_start;
    cyc();
    acc_ack[k] = 1'b0;
    start[k]   = 1'b0;
    chk("ack_busy", busy[k], 0);
    chk("ack_valid", acc_valid[k], 0);
    chk("ack_p_ready", p_ready[k], 0);
    if (v.ack_start) begin
      cyc();
      chk("ack_start_stays_idle", busy[k], 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst     = '1;
    start   = '0;
    p_valid = '0;
    acc_ack = '0;
    for (int k = 0; k < NCFG; k++) p_in[k] = '0;

    tbl.push_back('{0, '{126, 1, 122, -1, 0, 0, 0, 0}, 0, 1'b0, 1'b0, 0, 1'b0, 64'sd248, 1'b0});
    tbl.push_back('{1, '{1073676289, 1073676289, 1073676289, 1073676289,
                        1073676289, 1073676289, 1073676289, 1073676289},
                    3, 1'b0, 1'b0, 0, 1'b0, 64'sd8589410312, 1'b0});
    tbl.push_back('{2, '{1073676289, 1073676289, 1073676289, 0, 0, 0, 0, 0},
                    1, 1'b0, 1'b0, 0, 1'b0, -64'sd1073938429, 1'b1});
    tbl.push_back('{2, '{5, -7, 100, 0, 0, 0, 0, 0}, 2, 1'b0, 1'b0, 0, 1'b0, 64'sd98, 1'b0});
    tbl.push_back('{3, '{-718019225, -3709654, 0, 0, 0, 0, 0, 0},
                    0, 1'b0, 1'b0, 5, 1'b1, -64'sd721728879, 1'b0});
    tbl.push_back('{4, '{-126, 0, 0, 0, 0, 0, 0, 0}, 0, 1'b0, 1'b1, 0, 1'b0, -64'sd126, 1'b0});
    tbl.push_back('{0, '{-2147483647 - 1, -2147483647 - 1, -2147483647 - 1, -2147483647 - 1, 0, 0, 0, 0},
                    1, 1'b0, 1'b0, 0, 1'b0, -64'sd8589934592, 1'b0});
    tbl.push_back('{2, '{-2147483647 - 1, -1, 0, 0, 0, 0, 0, 0},
                    0, 1'b0, 1'b0, 1, 1'b0, 64'sd2147483647, 1'b1});
    tbl.push_back('{0, '{0, 0, 0, 0, 0, 0, 0, 0}, 2, 1'b1, 1'b0, 0, 1'b0, 64'sd0, 1'b0});
    tbl.push_back('{2, '{0, 0, 0, 0, 0, 0, 0, 0}, 2, 1'b1, 1'b0, 0, 1'b0, 64'sd0, 1'b0});
    tbl.push_back('{1, '{0, 0, 0, 0, 0, 0, 0, 0}, 1, 1'b1, 1'b0, 1, 1'b0, 64'sd0, 1'b0});

    repeat (2) @(negedge clk);
    for (int k = 0; k < NCFG; k++) begin
      chk("rst_acc", acc_sx[k], 0);
      chk("rst_valid", acc_valid[k], 0);
      chk("rst_ovf", ovf[k], 0);
      chk("rst_busy", busy[k], 0);
      chk("rst_p_ready", p_ready[k], 0);
    end
    rst = '0;
    cyc();

    foreach (tbl[i]) run_row(tbl[i]);

    // Asynchronous reset in the middle of an accumulation on the N_TERMS=4 instance
    start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      p_in[0]    = 32'd1000 * (i + 1);
      p_valid[0] = 1'b1;
      cyc();
      p_valid[0] = 1'b0;
    end
    chk("pre_rst_acc", acc_sx[0], 3000);
    #1 rst[0] = 1'b1;
    #1;
    chk("mid_rst_acc", acc_sx[0], 0);
    chk("mid_rst_valid", acc_valid[0], 0);
    chk("mid_rst_ovf", ovf[0], 0);
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_p_ready", p_ready[0], 0);
    #1 rst[0] = 1'b0;
    repeat (2) begin
      cyc();
      chk("post_rst_idle", busy[0], 0);
    end
    run_row('{0, '{1, 1, 1, 1, 0, 0, 0, 0}, 1, 1'b0, 1'b0, 0, 1'b0, 64'sd4, 1'b0});

    if (sb.size() != 0) chk("scoreboard_leftover", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/smac_acc.md
SMAC_ACC -- requirements
Module: smac_acc

Interface
REQ-001 The block SHALL have parameter N_TERMS, default 8, giving the number of products summed per accumulation; legal range is 1..255.
REQ-002 The block SHALL have parameter ACC_W, default 40, giving the accumulator width; legal range is 32..64.
REQ-003 Port clk  in  1  is the single clock, rising edge.
REQ-004 Port rst  in  1  is the reset: asynchronous, active-high.
REQ-005 Port start  in  1  requests a new accumulation.
REQ-006 Port p  in  32  carries a signed two's-complement product from the 16x16 signed multiplier.
REQ-007 Port p_valid  in  1  marks p as valid.
REQ-008 Port p_ready  out  1  means the block accepts p this cycle.
REQ-009 Port acc_out  out  ACC_W  carries the signed accumulated result.
REQ-010 Port acc_valid  out  1  means acc_out is final.
REQ-011 Port acc_ack  in  1  means the consumer has taken acc_out.
REQ-012 Port ovf  out  1  is a sticky signed-overflow flag for the current accumulation.
REQ-013 Port busy  out  1  is high in ACC or DONE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACC and DONE.
REQ-015 IDLE behaviour:
- p_ready=0, acc_valid=0, busy=0.
- start=1 goes to ACC next cycle.
- On that edge, the accumulator, the term counter and ovf all clear to 0.
REQ-016 ACC behaviour:
- p_ready=1 and busy=1.
- A transfer occurs on a clk edge where p_valid and p_ready are both 1.
- Each transfer adds p, sign-extended to ACC_W, to the accumulator and increments the counter.
REQ-017 When the transfer with counter value N_TERMS-1 occurs, the FSM SHALL enter DONE on that edge; acc_valid is high the following cycle (1-cycle latency from the last transfer).
REQ-018 Cycles in ACC with p_valid=0 SHALL leave the accumulator and counter unchanged (arbitrary stalls).
REQ-019 DONE behaviour:
- acc_valid=1, p_ready=0, busy=1.
- acc_out and ovf are held stable.
- acc_ack=1 returns the FSM to IDLE next cycle.
REQ-020 start SHALL be ignored in ACC and DONE; start and acc_ack both high in DONE SHALL go to IDLE only.
REQ-021 Addition SHALL wrap modulo 2^ACC_W (no saturation).
REQ-022 ovf SHALL set when a transfer's addends have equal sign bits and the sum's sign differs; it stays set until the next IDLE->ACC transition.
REQ-023 acc_out SHALL equal the accumulator register in all states; the value is only meaningful while acc_valid=1.
REQ-024 With N_TERMS=1, a single transfer SHALL move ACC->DONE.
REQ-025 p SHALL be ignored whenever p_ready=0.

Reset
REQ-026 While rst=1 (asynchronous assert), the block SHALL be in IDLE with:
- acc_out=0, acc_valid=0, ovf=0, busy=0, p_ready=0
- counter=0.
REQ-027 rst asserted mid-accumulation (ACC or DONE) SHALL discard all partial state immediately.
REQ-028 After rst deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-029 N_TERMS=4, ACC_W=40; start, then products 126, 1, 122, -1 back-to-back -> acc_valid one cycle after the 4th transfer, acc_out=248, ovf=0.
REQ-030 N_TERMS=8, ACC_W=40; 8 transfers of 1073676289 (0x7FFF*0x7FFF) with p_valid gaps of 0-3 cycles -> acc_out=8589410312, ovf=0, no transfer lost or duplicated.
REQ-031 N_TERMS=3, ACC_W=32; 3 transfers of 1073676289 -> acc_out=-1073938429 (wrapped), ovf=1; ovf clears on the next start.
REQ-032 N_TERMS=2; products -718019225 and -3709654 -> acc_out=-721728879; hold acc_ack=0 for 5 cycles -> acc_out and acc_valid stable; acc_ack=1 with start=1 -> IDLE, busy=0.
REQ-033 N_TERMS=4; rst pulsed after 2 transfers -> all outputs 0 in the same cycle; a new start followed by 4 transfers of 1 -> acc_out=4.
REQ-034 N_TERMS=1; start pulsed in ACC and DONE -> ignored; a single transfer of -126 -> acc_out=-126 after 1 cycle.
